ex_pipe_stage: RTL

EX_PIPE_STAGE -- requirements
Module: ex_pipe_stage

---
 rtl/ex_pkg.sv | 34 +++
 rtl/ex_mul_iter.sv | 59 +++++
 rtl/ex_pipe_stage.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_pkg
// Brief    : Shared operation and FSM state encodings for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_MUL  = 4'd14
    } ex_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WAIT = 2'd2
    } ex_state_e;

endpackage
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
// Module   : ex_mul_iter
// Brief    : Iterative shift-add multiplier retiring STEP_BITS multiplier bits
//            per step; keeps the low XLEN bits of the product.
// Revision : 1.0 - initial release
// ============================================================================
module ex_mul_iter #(
    parameter int XLEN      = 32,
    parameter int STEP_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            step_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] product_o,
    output logic [XLEN-1:0] product_next_o
);

    localparam int                 c_STEPS = XLEN / STEP_BITS;
    localparam int                 c_CNT_W = $clog2(c_STEPS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_STEPS - 1);

    logic [XLEN-1:0]    r_mcand;
    logic [XLEN-1:0]    r_mplier;
    logic [XLEN-1:0]    r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]    w_partial;

    // Multiplicand is pre-shifted each step, so the partial needs no offset.
    assign w_partial      = r_mcand * XLEN'(r_mplier[STEP_BITS-1:0]);
    assign product_next_o = r_acc + w_partial;
    assign product_o      = r_acc;
    assign done_o         = (r_cnt == c_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (start_i) begin
            r_mcand  <= a_i;
            r_mplier <= b_i;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (step_i) begin
            r_mcand  <= r_mcand << STEP_BITS;
            r_mplier <= r_mplier >> STEP_BITS;
            r_acc    <= product_next_o;
            r_cnt    <= r_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_pipe_stage
// Brief    : Execute stage with EX/WB output register, branch resolution and
//            an optional iterative multiplier (EX_PIPE_STAGE_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module ex_pipe_stage
    import ex_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int MUL_STEP_BITS = 1,
    parameter int RF_ADDR_W     = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  ex_op_e               op_i,
    input  logic [XLEN-1:0]      operand_a_i,
    input  logic [XLEN-1:0]      operand_b_i,
    input  logic [XLEN-1:0]      pc_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic [RF_ADDR_W-1:0] rf_waddr_i,
    input  logic                 rf_we_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XLEN-1:0]      rf_wdata_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic                 rf_we_o,
    output logic                 branch_taken_o,
    output logic [XLEN-1:0]      branch_target_o,
    output logic                 illegal_o,
    output logic                 busy_o
);

    localparam int c_SHAMT_W = $clog2(XLEN);

    ex_state_e            r_state;
    ex_state_e            w_state_next;
    logic                 r_out_valid;
    logic                 r_rf_we;
    logic                 r_taken;
    logic                 r_illegal;
    logic [XLEN-1:0]      r_wdata;
    logic [XLEN-1:0]      r_target;
    logic [RF_ADDR_W-1:0] r_waddr;

    logic                 w_out_free;
    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_load;
    logic                 w_mul_finish;
    logic [XLEN-1:0]      w_mul_result;
    logic [RF_ADDR_W-1:0] w_mul_waddr;
    logic                 w_mul_we;
    logic [XLEN-1:0]      w_mul_target;

    logic [XLEN-1:0]      w_target;
    logic [c_SHAMT_W-1:0] w_shamt;
    logic                 w_eq;
    logic                 w_lt;
    logic                 w_ltu;
    logic [XLEN-1:0]      w_iss_wdata;
    logic                 w_iss_we;
    logic                 w_iss_taken;
    logic                 w_iss_illegal;

    assign w_out_free = !r_out_valid || out_ready_i;
    assign in_ready_o = (r_state == ST_IDLE) && w_out_free;
    assign w_accept   = in_valid_i && in_ready_o && !flush_i;
    assign w_load     = (w_accept && !w_is_mul) || w_mul_finish;

    assign w_target = pc_i + imm_i;
    assign w_shamt  = operand_b_i[c_SHAMT_W-1:0];
    assign w_eq     = (operand_a_i == operand_b_i);
    assign w_lt     = ($signed(operand_a_i) < $signed(operand_b_i));
    assign w_ltu    = (operand_a_i < operand_b_i);

    // Single-cycle decode; branches and unsupported ops never write the RF.
    always_comb begin
        w_iss_wdata   = '0;
        w_iss_we      = rf_we_i;
        w_iss_taken   = 1'b0;
        w_iss_illegal = 1'b0;
        case (op_i)
            OP_ADD:  w_iss_wdata = operand_a_i + operand_b_i;
            OP_SUB:  w_iss_wdata = operand_a_i - operand_b_i;
            OP_AND:  w_iss_wdata = operand_a_i & operand_b_i;
            OP_OR:   w_iss_wdata = operand_a_i | operand_b_i;
            OP_XOR:  w_iss_wdata = operand_a_i ^ operand_b_i;
            OP_SLT:  w_iss_wdata = XLEN'(w_lt);
            OP_SLTU: w_iss_wdata = XLEN'(w_ltu);
            OP_SLL:  w_iss_wdata = operand_a_i << w_shamt;
            OP_SRL:  w_iss_wdata = operand_a_i >> w_shamt;
            OP_SRA:  w_iss_wdata = $unsigned($signed(operand_a_i) >>> w_shamt);
            OP_BEQ:  begin w_iss_we = 1'b0; w_iss_taken = w_eq;   end
            OP_BNE:  begin w_iss_we = 1'b0; w_iss_taken = !w_eq;  end
            OP_BLT:  begin w_iss_we = 1'b0; w_iss_taken = w_lt;   end
            OP_BGE:  begin w_iss_we = 1'b0; w_iss_taken = !w_lt;  end
            default: begin w_iss_we = 1'b0; w_iss_illegal = 1'b1; end
        endcase
    end

`ifdef EX_PIPE_STAGE_MUL_EN
    logic                 w_mul_start;
    logic                 w_mul_step;
    logic                 w_mul_done;
    logic                 w_mul_use_next;
    logic [XLEN-1:0]      w_prod;
    logic [XLEN-1:0]      w_prod_next;
    logic [RF_ADDR_W-1:0] r_mul_waddr;
    logic                 r_mul_we;
    logic [XLEN-1:0]      r_mul_target;

    assign w_is_mul = (op_i == OP_MUL);

    ex_mul_iter #(
        .XLEN      (XLEN),
        .STEP_BITS (MUL_STEP_BITS)
    ) u_mul_iter (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (w_mul_start),
        .step_i         (w_mul_step),
        .a_i            (operand_a_i),
        .b_i            (operand_b_i),
        .done_o         (w_mul_done),
        .product_o      (w_prod),
        .product_next_o (w_prod_next)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mul_waddr  <= '0;
            r_mul_we     <= 1'b0;
            r_mul_target <= '0;
        end else if (w_mul_start) begin
            r_mul_waddr  <= rf_waddr_i;
            r_mul_we     <= rf_we_i;
            r_mul_target <= w_target;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_mul_start    = 1'b0;
        w_mul_step     = 1'b0;
        w_mul_finish   = 1'b0;
        w_mul_use_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_mul_start  = 1'b1;
                    w_state_next = ST_MUL;
                end
            end
            ST_MUL: begin
                w_mul_step = 1'b1;
                if (w_mul_done) begin
                    if (w_out_free) begin
                        w_mul_finish   = 1'b1;
                        w_mul_use_next = 1'b1;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (w_out_free) begin
                    w_mul_finish = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            w_mul_finish = 1'b0;
            w_state_next = ST_IDLE;
        end
    end

    assign w_mul_result = w_mul_use_next ? w_prod_next : w_prod;
    assign w_mul_waddr  = r_mul_waddr;
    assign w_mul_we     = r_mul_we;
    assign w_mul_target = r_mul_target;
`else
    // MUL falls through the decode default and retires as illegal.
    assign w_is_mul     = 1'b0;
    assign w_state_next = ST_IDLE;
    assign w_mul_finish = 1'b0;
    assign w_mul_result = '0;
    assign w_mul_waddr  = '0;
    assign w_mul_we     = 1'b0;
    assign w_mul_target = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_wdata     <= '0;
            r_waddr     <= '0;
            r_rf_we     <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
            r_illegal   <= 1'b0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            if (w_mul_finish) begin
                r_wdata   <= w_mul_result;
                r_waddr   <= w_mul_waddr;
                r_rf_we   <= w_mul_we;
                r_taken   <= 1'b0;
                r_target  <= w_mul_target;
                r_illegal <= 1'b0;
            end else begin
                r_wdata   <= w_iss_wdata;
                r_waddr   <= rf_waddr_i;
                r_rf_we   <= w_iss_we;
                r_taken   <= w_iss_taken;
                r_target  <= w_target;
                r_illegal <= w_iss_illegal;
            end
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o     = r_out_valid;
    assign rf_wdata_o      = r_wdata;
    assign rf_waddr_o      = r_waddr;
    assign rf_we_o         = r_rf_we;
    assign branch_taken_o  = r_taken;
    assign branch_target_o = r_target;
    assign illegal_o       = r_illegal;
    assign busy_o          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
